pipe_stall_seq: RTL and testbench
=================================

PIPE_STALL_SEQ -- requirements
Module: pipe_stall_seq

Interface
REQ-001 SHALL have parameter MAX_HAZ, default 3, the maximum legal consecutive data-hazard stall cycles.
REQ-002 SHALL have parameter CNT_W, default 16, the width of the performance counters.
REQ-003 SHALL provide port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, synchronous, active-low (0 = reset).
REQ-005 SHALL provide port stallCtrl  input  1  data-hazard stall request from the hazard detector.
REQ-006 SHALL provide port startStall  input  1  first cycle of a new data-hazard stall.
REQ-007 SHALL provide port jumpFlush  input  1  jump resolved in ID/EX; flush the younger stages.
REQ-008 SHALL provide port takeBranch  input  1  branch taken; flush the younger stages.
REQ-009 SHALL provide port memBusy  input  1  data memory not ready; freeze the whole pipeline.
REQ-010 SHALL provide port pcEn  output  1  PC register write enable.
REQ-011 SHALL provide port ifidEn  output  1  IF/ID register write enable.
REQ-012 SHALL provide port ifidFlush  output  1  load a NOP into IF/ID.
REQ-013 SHALL provide port idexBubble  output  1  load a NOP into ID/EX.
REQ-014 SHALL provide port pipeEn  output  1  ID/EX, EX/MEM and MEM/WB write enable.
REQ-015 SHALL provide port state  output  2  registered class of the previous cycle.
REQ-016 SHALL provide port hazStallCnt  output  CNT_W  count of data-hazard stall cycles.
REQ-017 SHALL provide port memStallCnt  output  CNT_W  count of memory-freeze cycles.
REQ-018 SHALL provide port flushCnt  output  CNT_W  count of flush events.
REQ-019 SHALL provide port hazErr  output  1  sticky protocol-error flag.

Function
REQ-020 SHALL classify each cycle combinationally, in priority order, as MEM (memBusy), else FLUSH (jumpFlush|takeBranch), else HAZ (stallCtrl), else RUN.
REQ-021 SHALL encode the classes as RUN=0, HAZ=1, MEM=2, FLUSH=3.
REQ-022 In RUN, SHALL drive pcEn=1, ifidEn=1, pipeEn=1, ifidFlush=0, idexBubble=0.
REQ-023 In HAZ, SHALL drive pcEn=0, ifidEn=0, pipeEn=1, ifidFlush=0, idexBubble=1.
REQ-024 In MEM, SHALL drive pcEn=0, ifidEn=0, pipeEn=0, ifidFlush=0, idexBubble=0, so that all stages hold.
REQ-025 In FLUSH, SHALL drive pcEn=1, ifidEn=1, pipeEn=1, ifidFlush=1, idexBubble=1.
REQ-026 Control outputs SHALL respond in the same cycle as the inputs (zero latency); state SHALL be updated to the current class at each rising edge (one-cycle latency).
REQ-027 SHALL keep an internal run counter of consecutive HAZ cycles:
- loads 1 on a HAZ cycle with startStall=1;
- increments, saturating at MAX_HAZ+1, on a HAZ cycle with startStall=0;
- clears on any non-HAZ cycle.
REQ-028 A MEM cycle SHALL clear the run counter, so a freeze does not count toward the stall length.
REQ-029 SHALL set hazErr when the run counter would exceed MAX_HAZ.
REQ-030 SHALL set hazErr when startStall=1 while stallCtrl=0 and the class is HAZ or RUN.
REQ-031 hazErr SHALL remain set until reset.
REQ-032 hazStallCnt SHALL increment on every HAZ cycle, and memStallCnt on every MEM cycle.
REQ-033 flushCnt SHALL increment on a FLUSH cycle only when state≠FLUSH, so that back-to-back flush cycles count as one event.
REQ-034 All counters SHALL saturate at 2^CNT_W−1 and never wrap.
REQ-035 Simultaneous memBusy with a flush SHALL produce MEM; the flush request SHALL be honoured only on the first cycle with memBusy=0 on which it is still asserted.

Reset
REQ-036 With rst=0 sampled at a rising edge, SHALL set state=RUN, clear all counters, clear the run counter and clear hazErr.
REQ-037 While rst=0, SHALL force pcEn=0, ifidEn=0, pipeEn=0, ifidFlush=1, idexBubble=1, regardless of the other inputs.
REQ-038 Reset asserted mid-stall or mid-freeze SHALL abandon that operation; the first cycle after rst=1 SHALL be classified from inputs only.

Verification
REQ-039 Bench SHALL cover a data-hazard stall: startStall=1 and stallCtrl=1 for 1 cycle, then stallCtrl=1 for 2 more -> pcEn=0 and idexBubble=1 for 3 cycles; hazStallCnt=3; hazErr=0.
REQ-040 Bench SHALL cover an over-length stall: stallCtrl=1 for 4 cycles with startStall on the first only -> hazErr=1 after the 4th edge and still 1 after 10 RUN cycles.
REQ-041 Bench SHALL cover priority: memBusy=1, takeBranch=1, stallCtrl=1 together for 2 cycles -> pipeEn=0 and ifidFlush=0; memStallCnt=2; flushCnt=0; on the following cycle with takeBranch=1 only -> ifidFlush=1 and flushCnt=1.
REQ-042 Bench SHALL cover flush-event counting: jumpFlush=1 for 3 consecutive cycles, then 1 RUN cycle, then jumpFlush=1 for 1 cycle -> flushCnt=2.
REQ-043 Bench SHALL cover counter saturation: with CNT_W=4, memBusy=1 for 20 cycles -> memStallCnt=15, not 4.
REQ-044 Bench SHALL cover mid-stall reset: rst=0 on the 2nd cycle of a HAZ stall -> that cycle shows ifidFlush=1 and pcEn=0; after the edge, all counters=0 and state=0.

Source files
------------

// File: rtl/pipe_stall_seq.sv
// pipe_stall_seq: pipeline stall/flush sequencer with hazard checking and performance counters
module pipe_stall_seq #(
    parameter int MAX_HAZ = 3,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stallCtrl,
    input  logic             startStall,
    input  logic             jumpFlush,
    input  logic             takeBranch,
    input  logic             memBusy,
    output logic             pcEn,
    output logic             ifidEn,
    output logic             ifidFlush,
    output logic             idexBubble,
    output logic             pipeEn,
    output logic [1:0]       state,
    output logic [CNT_W-1:0] hazStallCnt,
    output logic [CNT_W-1:0] memStallCnt,
    output logic [CNT_W-1:0] flushCnt,
    output logic             hazErr
);
    typedef enum logic [1:0] {RUN = 2'd0, HAZ = 2'd1, MEM = 2'd2, FLUSH = 2'd3} cls_t;
    localparam int RW = $clog2(MAX_HAZ + 2);
    cls_t cls;
    logic [RW-1:0] runCnt, runNext;
    logic runErr, startErr;
    always_comb begin
        cls = memBusy ? MEM : (jumpFlush | takeBranch) ? FLUSH : stallCtrl ? HAZ : RUN;
        pcEn = rst && (cls == RUN || cls == FLUSH);
        ifidEn = rst && (cls == RUN || cls == FLUSH);
        pipeEn = rst && cls != MEM;
        ifidFlush = !rst || cls == FLUSH;
        idexBubble = !rst || cls == HAZ || cls == FLUSH;
        runNext = startStall ? RW'(1) : (runCnt == RW'(MAX_HAZ + 1)) ? runCnt : runCnt + RW'(1);
        runErr = cls == HAZ && runNext > RW'(MAX_HAZ);
        startErr = startStall && !stallCtrl && (cls == RUN || cls == HAZ);
    end
    // back-to-back flush cycles count as a single event, keyed off the previous class
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
            runCnt <= '0;
            hazErr <= 1'b0;
            hazStallCnt <= '0;
            memStallCnt <= '0;
            flushCnt <= '0;
        end else begin
            state <= cls;
            runCnt <= cls == HAZ ? runNext : '0;
            if (runErr || startErr) hazErr <= 1'b1;
            if (cls == HAZ && hazStallCnt != '1) hazStallCnt <= hazStallCnt + CNT_W'(1);
            if (cls == MEM && memStallCnt != '1) memStallCnt <= memStallCnt + CNT_W'(1);
            if (cls == FLUSH && state != FLUSH && flushCnt != '1) flushCnt <= flushCnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pipe_stall_seq.sv
// tb_pipe_stall_seq: directed scoreboard bench for pipe_stall_seq (CNT_W=4 to reach saturation)
module tb_pipe_stall_seq;
    logic clk = 1'b0;
    logic rst, stallCtrl, startStall, jumpFlush, takeBranch, memBusy;
    logic pcEn, ifidEn, ifidFlush, idexBubble, pipeEn, hazErr;
    logic [1:0] state;
    logic [3:0] hazStallCnt, memStallCnt, flushCnt;
    int nPass = 0;
    int nTotal = 0;
    typedef struct {
        string tag;
        logic [4:0] ctl;
    } exp_t;
    exp_t sb[$];

    pipe_stall_seq #(.MAX_HAZ(3), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .stallCtrl(stallCtrl), .startStall(startStall),
        .jumpFlush(jumpFlush), .takeBranch(takeBranch), .memBusy(memBusy),
        .pcEn(pcEn), .ifidEn(ifidEn), .ifidFlush(ifidFlush), .idexBubble(idexBubble),
        .pipeEn(pipeEn), .state(state), .hazStallCnt(hazStallCnt),
        .memStallCnt(memStallCnt), .flushCnt(flushCnt), .hazErr(hazErr)
    );

    always #5 clk = ~clk;

    // expected {pcEn, ifidEn, ifidFlush, idexBubble, pipeEn} from the class tables
    function automatic logic [4:0] expCtl(input logic r, input logic m, input logic f, input logic s);
        if (!r) return 5'b00110;
        if (m) return 5'b00000;
        if (f) return 5'b11111;
        if (s) return 5'b00011;
        return 5'b11001;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTotal++;
        assert (obs === exp) nPass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // drive one cycle at the falling edge, compare control outputs before the rising edge
    task automatic step(input string tag, input logic r, input logic s, input logic st,
                        input logic jf, input logic tb, input logic m);
        exp_t e;
        @(negedge clk);
        rst = r; stallCtrl = s; startStall = st; jumpFlush = jf; takeBranch = tb; memBusy = m;
        sb.push_back('{tag, expCtl(r, m, jf | tb, s)});
        #1;
        e = sb.pop_front();
        check(e.tag, {27'd0, pcEn, ifidEn, ifidFlush, idexBubble, pipeEn}, {27'd0, e.ctl});
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        step("reset", 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        rst = 0; stallCtrl = 0; startStall = 0; jumpFlush = 0; takeBranch = 0; memBusy = 0;
        step("reset_busy", 0, 1, 1, 1, 1, 1);
        check("rst_state", state, 0);
        check("rst_haz", hazStallCnt, 0);
        check("rst_mem", memStallCnt, 0);
        check("rst_flush", flushCnt, 0);
        check("rst_err", hazErr, 0);
        step("run", 1, 0, 0, 0, 0, 0);
        check("run_state", state, 0);
        // legal three-cycle hazard stall
        step("haz1", 1, 1, 1, 0, 0, 0);
        step("haz2", 1, 1, 0, 0, 0, 0);
        step("haz3", 1, 1, 0, 0, 0, 0);
        check("haz_cnt", hazStallCnt, 3);
        check("haz_state", state, 1);
        check("haz_err", hazErr, 0);
        step("haz_end", 1, 0, 0, 0, 0, 0);
        // over-length stall
        step("ovl1", 1, 1, 1, 0, 0, 0);
        step("ovl2", 1, 1, 0, 0, 0, 0);
        step("ovl3", 1, 1, 0, 0, 0, 0);
        check("ovl_err3", hazErr, 0);
        step("ovl4", 1, 1, 0, 0, 0, 0);
        check("ovl_err4", hazErr, 1);
        check("ovl_cnt", hazStallCnt, 7);
        for (int i = 0; i < 10; i++) step("ovl_run", 1, 0, 0, 0, 0, 0);
        check("ovl_sticky", hazErr, 1);
        doReset();
        check("err_clr", hazErr, 0);
        // priority: memory freeze beats flush and hazard
        step("pri1", 1, 1, 0, 0, 1, 1);
        step("pri2", 1, 1, 0, 0, 1, 1);
        check("pri_mem", memStallCnt, 2);
        check("pri_flush0", flushCnt, 0);
        check("pri_state", state, 2);
        step("pri_br", 1, 0, 0, 0, 1, 0);
        check("pri_flush1", flushCnt, 1);
        check("pri_state3", state, 3);
        check("pri_err", hazErr, 0);
        doReset();
        // flush event counting
        step("jf1", 1, 0, 0, 1, 0, 0);
        step("jf2", 1, 0, 0, 1, 0, 0);
        step("jf3", 1, 0, 0, 1, 0, 0);
        check("jf_once", flushCnt, 1);
        step("jf_run", 1, 0, 0, 0, 0, 0);
        step("jf4", 1, 0, 0, 1, 0, 0);
        check("jf_two", flushCnt, 2);
        doReset();
        // saturation
        for (int i = 0; i < 20; i++) step("sat", 1, 0, 0, 0, 0, 1);
        check("sat_mem", memStallCnt, 15);
        doReset();
        // mid-stall reset
        step("ms1", 1, 1, 1, 0, 0, 0);
        check("ms_cnt", hazStallCnt, 1);
        step("ms_rst", 0, 1, 0, 0, 0, 0);
        check("ms_state", state, 0);
        check("ms_haz", hazStallCnt, 0);
        check("ms_mem", memStallCnt, 0);
        check("ms_flush", flushCnt, 0);
        step("ms_after", 1, 1, 0, 0, 0, 0);
        check("ms_after_state", state, 1);
        check("ms_after_err", hazErr, 0);
        // startStall without stallCtrl is a protocol error
        step("bad_start", 1, 0, 1, 0, 0, 0);
        check("bad_start_err", hazErr, 1);
        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end
endmodule
